// File: rtl/bus_pair_pkg.sv
// Shared types and index-mapping helpers for the dual-bus receive path.
package bus_pair_pkg;
  localparam int HALF_W = 5;
  localparam int IDX_HI = 2;
  localparam int IDX_LO = -2;

  typedef logic [2*HALF_W-1:0] word_t;

  typedef enum logic [1:0] {EMPTY, PARTIAL, FULL} state_t;

  // Word layout is by index: bits 9..5 = a[2..-2], bits 4..0 = b[2..-2].
  function automatic word_t pack_pair(input logic [IDX_HI:IDX_LO] a,
                                      input logic [IDX_LO:IDX_HI] b);
    return {a, b[2], b[1], b[0], b[-1], b[-2]};
  endfunction

  function automatic void unpack_pair(input word_t w,
                                      output logic [IDX_HI:IDX_LO] a,
                                      output logic [IDX_LO:IDX_HI] b);
    a = w[9:5];
    b = {w[0], w[1], w[2], w[3], w[4]};
  endfunction
endpackage

// File: rtl/bus_pair_fifo.sv
// Circular word buffer with wrapping pointers and an occupancy count.
module bus_pair_fifo
  import bus_pair_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  word_t            wdata,
  output word_t            rdata,
  output logic [CNT_W-1:0] count
);
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

  word_t            mem [DEPTH];
  logic [PTR_W-1:0] wptr;
  logic [PTR_W-1:0] rptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && (count != DEPTH_CNT);
  assign do_pop  = pop && (count != '0);
  assign rdata   = mem[rptr];

  // Storage is cleared on reset so the idle output reads as zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wptr] <= wdata;
        wptr      <= wptr + PTR_W'(1);
      end
      if (do_pop) rptr <= rptr + PTR_W'(1);
      if (do_push && !do_pop) count <= count + CNT_W'(1);
      else if (do_pop && !do_push) count <= count - CNT_W'(1);
    end
  end
endmodule

// File: rtl/bus_pair_rx.sv
// Dual-bus receiver: index-preserving pack, FIFO buffering, valid/ready output.
// Optional even-parity drop with sticky error when BUS_PAIR_RX_PARITY_EN is defined.
module bus_pair_rx
  import bus_pair_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:-2]      i0,
  input  logic [-2:2]      i1,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2:-2]      o0,
  output logic [-2:2]      o1,
`ifdef BUS_PAIR_RX_PARITY_EN
  input  logic             in_par,
  output logic             par_err,
`endif
  output logic [CNT_W-1:0] count
);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);

  state_t state_q;
  word_t  wr_word;
  word_t  rd_word;
  logic   wr;
  logic   rd;

  assign in_ready  = (state_q != FULL);
  assign out_valid = (state_q != EMPTY);
  assign rd        = out_valid && out_ready;
  assign wr_word   = pack_pair(i0, i1);

`ifdef BUS_PAIR_RX_PARITY_EN
  logic par_ok;
  assign par_ok = ~^{i0, i1, in_par};
  assign wr     = in_valid && in_ready && par_ok;

  // A rejected pair still completes its handshake; only the flag records it.
  always_ff @(posedge clk) begin
    if (rst) par_err <= 1'b0;
    else if (in_valid && in_ready && !par_ok) par_err <= 1'b1;
  end
`else
  assign wr = in_valid && in_ready;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
    end else begin
      unique case (state_q)
        EMPTY:   if (wr) state_q <= PARTIAL;
        PARTIAL: begin
          if (wr && !rd && count == LAST_CNT) state_q <= FULL;
          else if (rd && !wr && count == ONE_CNT) state_q <= EMPTY;
        end
        FULL:    if (rd) state_q <= PARTIAL;
        default: state_q <= EMPTY;
      endcase
    end
  end

  bus_pair_fifo #(
    .DEPTH(DEPTH),
    .CNT_W(CNT_W)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (wr),
    .pop  (rd),
    .wdata(wr_word),
    .rdata(rd_word),
    .count(count)
  );

  always_comb begin
    o0 = '0;
    o1 = '0;
    unpack_pair(rd_word, o0, o1);
  end
endmodule

// File: tb/tb_bus_pair_rx.sv
// Directed and random bench for bus_pair_rx against a queue-based reference.
module tb_bus_pair_rx;
  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [2:-2]      i0;
  logic [-2:2]      i1;
  logic             out_valid;
  logic             out_ready;
  logic [2:-2]      o0;
  logic [-2:2]      o1;
  logic [CNT_W-1:0] count;
`ifdef BUS_PAIR_RX_PARITY_EN
  logic             in_par;
  logic             par_err;
`endif

  always #5 clk = ~clk;

  bus_pair_rx #(
    .DEPTH(DEPTH),
    .CNT_W(CNT_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .i0       (i0),
    .i1       (i1),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .o0       (o0),
    .o1       (o1),
`ifdef BUS_PAIR_RX_PARITY_EN
    .in_par   (in_par),
    .par_err  (par_err),
`endif
    .count    (count)
  );

  // Reference: pairs kept in their own declared types; outputs must equal inputs by index.
  logic [2:-2] q0[$];
  logic [-2:2] q1[$];
  bit          exp_perr;
  int          compared;
  int          mismatched;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag);
    chk({tag, ".count"}, 32'(count), 32'(q0.size()));
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(q0.size() != 0));
    chk({tag, ".in_ready"}, 32'(in_ready), 32'(q0.size() != DEPTH));
    if (q0.size() != 0) begin
      chk({tag, ".o0"}, 32'(o0), 32'(q0[0]));
      chk({tag, ".o1"}, 32'(o1), 32'(q1[0]));
    end
`ifdef BUS_PAIR_RX_PARITY_EN
    chk({tag, ".par_err"}, 32'(par_err), 32'(exp_perr));
`endif
  endtask

  task automatic step(input logic iv, input logic [2:-2] a, input logic [-2:2] b,
                      input logic orr, input logic bad, input string tag);
    bit acc;
    bit pop;
    bit good;
    in_valid  = iv;
    i0        = a;
    i1        = b;
    out_ready = orr;
`ifdef BUS_PAIR_RX_PARITY_EN
    in_par    = (^{a, b}) ^ bad;
`endif
    good = !bad;
    @(posedge clk);
    acc = iv && (q0.size() != DEPTH) && good;
    if (iv && (q0.size() != DEPTH) && !good) exp_perr = 1'b1;
    pop = orr && (q0.size() != 0);
    if (pop) begin
      void'(q0.pop_front());
      void'(q1.pop_front());
    end
    if (acc) begin
      q0.push_back(a);
      q1.push_back(b);
    end
    #1;
    check_state(tag);
  endtask

  task automatic rst_step(input logic iv, input string tag);
    rst       = 1'b1;
    in_valid  = iv;
    i0        = 5'($urandom);
    i1        = 5'($urandom);
    out_ready = 1'($urandom);
`ifdef BUS_PAIR_RX_PARITY_EN
    in_par    = 1'($urandom);
`endif
    @(posedge clk);
    q0.delete();
    q1.delete();
    exp_perr = 1'b0;
    #1;
    rst      = 1'b0;
    in_valid = 1'b0;
    check_state(tag);
    chk({tag, ".o0_zero"}, 32'(o0), 32'd0);
    chk({tag, ".o1_zero"}, 32'(o1), 32'd0);
  endtask

  initial begin
    logic [-2:2] b_hi;
    logic [-2:2] b_lo;
    compared   = 0;
    mismatched = 0;
    exp_perr   = 1'b0;

    rst_step(1'b0, "reset0");
    rst_step(1'b0, "reset1");

    // i1 with only index 2 set is packed 5'b00001 in the ascending frame.
    b_hi    = '0;
    b_hi[2] = 1'b1;
    step(1'b1, 5'b10110, b_hi, 1'b0, 1'b0, "first");
    chk("first.o0_const", 32'(o0), 32'h16);
    chk("first.o1_idx2", 32'(o1[2]), 32'd1);
    chk("first.o1_rest", 32'({o1[-2], o1[-1], o1[0], o1[1]}), 32'd0);

    for (int n = 0; n < 3; n++) step(1'b1, 5'($urandom), 5'($urandom), 1'b0, 1'b0, "fill");
    chk("full.in_ready", 32'(in_ready), 32'd0);
    step(1'b1, 5'($urandom), 5'($urandom), 1'b0, 1'b0, "over");
    chk("over.count", 32'(count), 32'(DEPTH));

    step(1'b1, 5'($urandom), 5'($urandom), 1'b1, 1'b0, "full_pp");
    chk("full_pp.count", 32'(count), 32'(DEPTH - 1));
    chk("full_pp.in_ready", 32'(in_ready), 32'd1);

    for (int n = 0; n < DEPTH && q0.size() != 0; n++)
      step(1'b0, 5'($urandom), 5'($urandom), 1'b1, 1'b0, "drain");
    step(1'b1, 5'($urandom), 5'($urandom), 1'b1, 1'b0, "empty_pp");
    for (int n = 0; n < 10; n++) begin
      step(1'b1, 5'($urandom), 5'($urandom), 1'b1, 1'b0, "stream");
      chk("stream.count1", 32'(count), 32'd1);
    end

    for (int n = 0; n < 3; n++) step(1'b1, 5'($urandom), 5'($urandom), 1'b0, 1'b0, "pre_rst");
    rst_step(1'b1, "mid_rst");

    // Index -2 alone is packed 5'b10000; it must come back at o1[-2].
    b_lo     = '0;
    b_lo[-2] = 1'b1;
    step(1'b1, 5'b00001, b_lo, 1'b0, 1'b0, "idx_lo");
    chk("idx_lo.o1m2", 32'(o1[-2]), 32'd1);
    chk("idx_lo.o1", 32'(o1), 32'h10);

    for (int n = 0; n < 300; n++)
      step($urandom_range(0, 3) != 0, 5'($urandom), 5'($urandom),
           $urandom_range(0, 2) != 0, 1'b0, "rand");

`ifdef BUS_PAIR_RX_PARITY_EN
    rst_step(1'b0, "par_rst");
    step(1'b1, 5'($urandom), 5'($urandom), 1'b0, 1'b1, "par_bad");
    chk("par_bad.count", 32'(count), 32'd0);
    chk("par_bad.err", 32'(par_err), 32'd1);
    step(1'b1, 5'($urandom), 5'($urandom), 1'b0, 1'b0, "par_good");
    chk("par_good.count", 32'(count), 32'd1);
    chk("par_good.err", 32'(par_err), 32'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
